sqrt_vec_seq: RTL and testbench
===============================

Name: sqrt_vec_seq

Overview:
- Upstream/downstream sequencer for the single-operand fp16 square-root unit `sqrt_fp16`.
- Accepts a vector of LANES fp16 operands plus a lane mask from the vector issue stage, serialises active lanes into the sqrt unit one at a time, and gathers the results.
- Presents the reassembled vector to writeback through a valid/ready handshake.
- A per-element watchdog prevents a hung sqrt unit from stalling the vector pipe.

Parameters:
- LANES, 4, number of fp16 elements per vector (≥1).
- TIMEOUT, 64, max cycles spent in WAIT for one element before forcing a result.
- IDX_W, $clog2(LANES) (min 1), lane index width.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- vec_valid_in  in  1  upstream vector valid
- vec_ready_in  out  1  block can accept a vector
- vec_operand  in  LANES*16  lane i at [16i+15:16i]
- vec_mask  in  LANES  1 = lane active
- vec_valid_out  out  1  result vector valid
- vec_ready_out  in  1  writeback ready
- vec_result  out  LANES*16  result vector, same packing
- vec_timeout  out  1  ≥1 lane timed out in the presented vector
- sq_valid_in  out  1  to sqrt unit valid_in
- sq_ready_in  in  1  from sqrt unit ready_in
- sq_operand  out  16  to sqrt unit operand
- sq_valid_out  in  1  from sqrt unit valid_out
- sq_ready_out  out  1  to sqrt unit ready_out
- sq_result  in  16  from sqrt unit result
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; vec_ready_in=1; vec_valid_out=0; vec_result=0; vec_timeout=0; sq_valid_in=0; sq_ready_out=0; sq_operand=0; busy=0; internal operand/result/mask registers and watchdog counter cleared. Reset mid-operation discards everything; an in-flight sqrt result arriving after reset is ignored because sq_ready_out=0 in IDLE.
- vec_ready_in = (state==IDLE). Accept on vec_valid_in & vec_ready_in: latch operands into opnd_q, mask into pend_q, clear res_q and timeout flag.
- States:
  - IDLE
    - On accept, if mask==0 → DONE.
    - Otherwise → ISSUE with idx = lowest set bit of mask.
  - ISSUE
    - Drive sq_valid_in=1 and sq_operand=opnd_q[idx].
    - On sq_ready_in=1 the element is accepted that cycle → WAIT, with the watchdog counter cleared.
  - WAIT
    - sq_ready_out=1; counter increments each cycle.
    - On sq_valid_out=1: res_q[idx]=sq_result; clear pend_q[idx].
    - Else if counter==TIMEOUT-1: res_q[idx]=16'h7E00 (qNaN); set timeout flag; clear pend_q[idx].
    - Then, if the remaining pend_q is nonzero → ISSUE with idx = next lowest set bit. Otherwise → DONE.
    - If sq_valid_out and the timeout coincide, the real result wins and the flag is not set.
  - DONE
    - vec_valid_out=1; vec_result=res_q; vec_timeout=flag.
    - Hold stable until vec_ready_out=1, then → IDLE. vec_ready_in rises the next cycle (no same-cycle accept in DONE).
- Masked lanes: res_q[i] = opnd_q[i], passed through unchanged and never issued.
- sq_valid_in is asserted only in ISSUE. sq_ready_out is asserted only in WAIT. The block never has more than one element outstanding.
- Latency for k active lanes, each sqrt taking S cycles from accept to valid_out: 1 + k·(1+S) cycles from vector accept to vec_valid_out. With k=0: vec_valid_out 1 cycle after accept.
- A stray sq_valid_out outside WAIT is ignored.

Test Plan:
- Stub sqrt (latency 8, exact model). LANES=4, mask=4'hF, operands {4400,3C00,4C00,5400} (4,1,16,64) → vec_result {4000,3C00,4400,4800}, vec_timeout=0, valid_out 37 cycles after accept, exactly 4 sq_valid_in handshakes.
- mask=4'b0101, operands {4400,BC00,4C00,7C00} → lanes 0,2 = 4000,4400; lanes 1,3 pass through BC00,7C00; exactly 2 sqrt issues in order lane0 then lane2.
- mask=0 → vec_valid_out 1 cycle after accept, vec_result == vec_operand, no sq_valid_in pulse.
- Stub never returns for lane 1, TIMEOUT=64 → lane1=7E00, vec_timeout=1, other lanes correct; stub's sq_valid_out made coincident with the timeout cycle in a rerun → real result kept, vec_timeout=0.
- vec_ready_out held low 20 cycles in DONE → vec_valid_out/vec_result stable, vec_ready_in=0, new vec_valid_in not accepted; release → IDLE, accept next vector the following cycle.
- Assert nRST during WAIT of lane 2 → all outputs at reset values immediately; a subsequent stub sq_valid_out is ignored; next vector completes correctly.

Source files
------------

// File: rtl/sqrt_vec_seq.sv
// Vector sequencer for the scalar fp16 square-root unit: issues active lanes one at a time,
// gathers results (with a per-element watchdog) and presents the vector to writeback.
module sqrt_vec_seq #(
   parameter int LANES   = 4,
   parameter int TIMEOUT = 64,
   parameter int IDX_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                vec_valid_in,
   output logic                vec_ready_in,
   input  logic [LANES*16-1:0] vec_operand,
   input  logic [LANES-1:0]    vec_mask,
   output logic                vec_valid_out,
   input  logic                vec_ready_out,
   output logic [LANES*16-1:0] vec_result,
   output logic                vec_timeout,
   output logic                sq_valid_in,
   input  logic                sq_ready_in,
   output logic [15:0]         sq_operand,
   input  logic                sq_valid_out,
   output logic                sq_ready_out,
   input  logic [15:0]         sq_result,
   output logic                busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [LANES*16-1:0] opnd_q;
   logic [LANES*16-1:0] res_q, res_d;
   logic [LANES-1:0]    pend_q, pend_d;
   logic                flag_q, flag_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                accept;
   logic                timed_out;
   logic [LANES-1:0]    pend_clr;

   function automatic logic [IDX_W-1:0] lowest(input logic [LANES-1:0] v);
      lowest = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (v[i]) lowest = IDX_W'(i);
      end
   endfunction

   assign accept    = vec_valid_in && (state_q == ST_IDLE);
   assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
   assign pend_clr  = pend_q & ~(LANES'(1) << idx_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      res_d   = res_q;
      pend_d  = pend_q;
      flag_d  = flag_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (vec_valid_in) begin
               // Masked lanes are preloaded with their operand so they pass straight through.
               for (int i = 0; i < LANES; i++) begin
                  res_d[16*i +: 16] = vec_mask[i] ? 16'h0000 : vec_operand[16*i +: 16];
               end
               pend_d = vec_mask;
               flag_d = 1'b0;
               if (vec_mask == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ISSUE;
                  idx_d   = lowest(vec_mask);
               end
            end
         end
         ST_ISSUE: begin
            if (sq_ready_in) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A real result arriving on the watchdog's last cycle takes priority.
            if (sq_valid_out || timed_out) begin
               for (int i = 0; i < LANES; i++) begin
                  if (IDX_W'(i) == idx_q) begin
                     res_d[16*i +: 16] = sq_valid_out ? sq_result : 16'h7E00;
                  end
               end
               if (!sq_valid_out) flag_d = 1'b1;
               pend_d = pend_clr;
               if (pend_clr != '0) begin
                  state_d = ST_ISSUE;
                  idx_d   = lowest(pend_clr);
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
            if (vec_ready_out) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         opnd_q  <= '0;
         res_q   <= '0;
         pend_q  <= '0;
         flag_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         pend_q  <= pend_d;
         flag_q  <= flag_d;
         cnt_q   <= cnt_d;
         if (accept) opnd_q <= vec_operand;
      end
   end

   always_comb begin
      sq_operand = '0;
      if (state_q == ST_ISSUE) begin
         for (int i = 0; i < LANES; i++) begin
            if (IDX_W'(i) == idx_q) sq_operand = opnd_q[16*i +: 16];
         end
      end
   end

   assign vec_ready_in  = (state_q == ST_IDLE);
   assign vec_valid_out = (state_q == ST_DONE);
   assign vec_result    = (state_q == ST_DONE) ? res_q : '0;
   assign vec_timeout   = (state_q == ST_DONE) && flag_q;
   assign sq_valid_in   = (state_q == ST_ISSUE);
   assign sq_ready_out  = (state_q == ST_WAIT);
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sqrt_vec_seq.sv
// Bench for sqrt_vec_seq: latency-programmable sqrt stub, scoreboard of expected vectors.
module tb_sqrt_vec_seq;

   localparam int LANES = 4;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        vec_valid_in = 1'b0;
   logic        vec_ready_in;
   logic [63:0] vec_operand = '0;
   logic [3:0]  vec_mask = '0;
   logic        vec_valid_out;
   logic        vec_ready_out = 1'b0;
   logic [63:0] vec_result;
   logic        vec_timeout;
   logic        sq_valid_in;
   logic        sq_ready_in;
   logic [15:0] sq_operand;
   logic        sq_valid_out;
   logic        sq_ready_out;
   logic [15:0] sq_result;
   logic        busy;

   sqrt_vec_seq #(.LANES(LANES), .TIMEOUT(64)) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .vec_valid_in (vec_valid_in),
      .vec_ready_in (vec_ready_in),
      .vec_operand  (vec_operand),
      .vec_mask     (vec_mask),
      .vec_valid_out(vec_valid_out),
      .vec_ready_out(vec_ready_out),
      .vec_result   (vec_result),
      .vec_timeout  (vec_timeout),
      .sq_valid_in  (sq_valid_in),
      .sq_ready_in  (sq_ready_in),
      .sq_operand   (sq_operand),
      .sq_valid_out (sq_valid_out),
      .sq_ready_out (sq_ready_out),
      .sq_result    (sq_result),
      .busy         (busy)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass = 0;
   int acc_cyc = 0;

   logic [63:0] exp_res_q[$];
   logic        exp_to_q[$];
   int          exp_lat_q[$];
   logic [15:0] issued_q[$];

   // Exact for the test operands; other inputs get an arbitrary but deterministic image.
   function automatic logic [15:0] sq_model(input logic [15:0] x);
      case (x)
         16'h4400: sq_model = 16'h4000;
         16'h3C00: sq_model = 16'h3C00;
         16'h4C00: sq_model = 16'h4400;
         16'h5400: sq_model = 16'h4800;
         default:  sq_model = x ^ 16'hA5A5;
      endcase
   endfunction

   // sqrt stub
   logic        st_busy = 1'b0;
   int          st_cnt = 0;
   logic [15:0] st_res = '0;
   int          st_lat = 8;
   logic        drop_en = 1'b0;
   logic [15:0] drop_op = '0;
   logic        st_flush = 1'b0;

   assign sq_ready_in  = !st_busy;
   assign sq_valid_out = st_busy && (st_cnt == 0);
   assign sq_result    = st_res;

   always @(posedge CLK) begin
      if (st_flush) begin
         st_busy <= 1'b0;
      end else if (sq_valid_in && sq_ready_in) begin
         if (!(drop_en && sq_operand == drop_op)) begin
            st_busy <= 1'b1;
            st_cnt  <= st_lat - 1;
            st_res  <= sq_model(sq_operand);
         end
      end else if (st_busy) begin
         if (st_cnt > 0) st_cnt <= st_cnt - 1;
         else if (sq_ready_out) st_busy <= 1'b0;
      end
   end

   always @(posedge CLK) begin
      if (sq_valid_in && sq_ready_in) issued_q.push_back(sq_operand);
   end

   task automatic send(input logic [63:0] op, input logic [3:0] m, input logic [63:0] e_res,
                       input logic e_to, input int e_lat);
      int guard = 0;
      vec_operand  = op;
      vec_mask     = m;
      vec_valid_in = 1'b1;
      while (!vec_ready_in && guard < 500) begin
         @(posedge CLK); #1;
         guard++;
      end
      if (!vec_ready_in) begin
         n_checks++;
         $display("FAIL accept_wait: vec_ready_in got 0 want 1 within 500 cycles");
      end
      @(posedge CLK); #1;
      acc_cyc      = cyc;
      vec_valid_in = 1'b0;
      exp_res_q.push_back(e_res);
      exp_to_q.push_back(e_to);
      exp_lat_q.push_back(e_lat);
   endtask

   task automatic collect(output logic [63:0] res, output logic to, output int lat,
                          output logic ok);
      int guard = 0;
      while (!vec_valid_out && guard < 2000) begin
         @(posedge CLK); #1;
         guard++;
      end
      ok  = vec_valid_out;
      lat = cyc - acc_cyc + 1;
      res = vec_result;
      to  = vec_timeout;
      if (ok) begin
         vec_ready_out = 1'b1;
         @(posedge CLK); #1;
         vec_ready_out = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLK);
      #1;
      n_checks++;
      if ({vec_ready_in, vec_valid_out, vec_timeout, sq_valid_in, sq_ready_out, busy} !== 6'b100000)
         $display("FAIL reset_ctrl: got %b want 100000",
                  {vec_ready_in, vec_valid_out, vec_timeout, sq_valid_in, sq_ready_out, busy});
      else n_pass++;
      n_checks++;
      if (vec_result !== 64'h0) $display("FAIL reset_result: got %h want 0", vec_result);
      else n_pass++;
      n_checks++;
      if (sq_operand !== 16'h0) $display("FAIL reset_sq_operand: got %h want 0", sq_operand);
      else n_pass++;
      nRST = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_full();
      logic [63:0] res, e_res;
      logic to, ok, e_to;
      int lat, e_lat;
      issued_q.delete();
      send({16'h5400, 16'h4C00, 16'h3C00, 16'h4400}, 4'hF,
           {16'h4800, 16'h4400, 16'h3C00, 16'h4000}, 1'b0, 37);
      collect(res, to, lat, ok);
      e_res = exp_res_q.pop_front(); e_to = exp_to_q.pop_front(); e_lat = exp_lat_q.pop_front();
      n_checks++;
      if (!ok) $display("FAIL full_valid: vec_valid_out got 0 want 1");
      else n_pass++;
      n_checks++;
      if (res !== e_res) $display("FAIL full_result: got %h want %h", res, e_res);
      else n_pass++;
      n_checks++;
      if (to !== e_to) $display("FAIL full_timeout: got %b want %b", to, e_to);
      else n_pass++;
      n_checks++;
      if (lat !== e_lat) $display("FAIL full_latency: got %0d want %0d", lat, e_lat);
      else n_pass++;
      n_checks++;
      if (issued_q.size() !== 4) $display("FAIL full_issues: got %0d want 4", issued_q.size());
      else n_pass++;
   endtask

   task automatic test_partial();
      logic [63:0] res, e_res;
      logic to, ok, e_to;
      int lat, e_lat;
      issued_q.delete();
      send({16'h7C00, 16'h4C00, 16'hBC00, 16'h4400}, 4'b0101,
           {16'h7C00, 16'h4400, 16'hBC00, 16'h4000}, 1'b0, 19);
      collect(res, to, lat, ok);
      e_res = exp_res_q.pop_front(); e_to = exp_to_q.pop_front(); e_lat = exp_lat_q.pop_front();
      n_checks++;
      if (!ok || res !== e_res || to !== e_to)
         $display("FAIL partial_result: got %h/%b want %h/%b", res, to, e_res, e_to);
      else n_pass++;
      n_checks++;
      if (lat !== e_lat) $display("FAIL partial_latency: got %0d want %0d", lat, e_lat);
      else n_pass++;
      n_checks++;
      if (issued_q.size() !== 2 || issued_q[0] !== 16'h4400 || issued_q[1] !== 16'h4C00)
         $display("FAIL partial_issue_order: got %0d issues want 2 (4400 then 4C00)",
                  issued_q.size());
      else n_pass++;
   endtask

   task automatic test_empty();
      logic [63:0] res, e_res;
      logic to, ok, e_to;
      int lat, e_lat;
      issued_q.delete();
      send(64'h1234_5678_9ABC_DEF0, 4'h0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1);
      collect(res, to, lat, ok);
      e_res = exp_res_q.pop_front(); e_to = exp_to_q.pop_front(); e_lat = exp_lat_q.pop_front();
      n_checks++;
      if (!ok || res !== e_res || to !== e_to)
         $display("FAIL empty_result: got %h/%b want %h/%b", res, to, e_res, e_to);
      else n_pass++;
      n_checks++;
      if (lat !== e_lat) $display("FAIL empty_latency: got %0d want %0d", lat, e_lat);
      else n_pass++;
      n_checks++;
      if (issued_q.size() !== 0) $display("FAIL empty_issues: got %0d want 0", issued_q.size());
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic [63:0] res, e_res;
      logic to, ok, e_to;
      int lat, e_lat;
      drop_en = 1'b1;
      drop_op = 16'h3C00;
      send({16'h5400, 16'h4C00, 16'h3C00, 16'h4400}, 4'hF,
           {16'h4800, 16'h4400, 16'h7E00, 16'h4000}, 1'b1, 93);
      collect(res, to, lat, ok);
      e_res = exp_res_q.pop_front(); e_to = exp_to_q.pop_front(); e_lat = exp_lat_q.pop_front();
      n_checks++;
      if (!ok || res !== e_res) $display("FAIL timeout_result: got %h want %h", res, e_res);
      else n_pass++;
      n_checks++;
      if (to !== e_to) $display("FAIL timeout_flag: got %b want %b", to, e_to);
      else n_pass++;
      n_checks++;
      if (lat !== e_lat) $display("FAIL timeout_latency: got %0d want %0d", lat, e_lat);
      else n_pass++;
      // Result lands on the watchdog's final cycle for every lane.
      drop_en = 1'b0;
      st_lat  = 64;
      send({16'h5400, 16'h4C00, 16'h3C00, 16'h4400}, 4'hF,
           {16'h4800, 16'h4400, 16'h3C00, 16'h4000}, 1'b0, 261);
      collect(res, to, lat, ok);
      e_res = exp_res_q.pop_front(); e_to = exp_to_q.pop_front(); e_lat = exp_lat_q.pop_front();
      st_lat = 8;
      n_checks++;
      if (!ok || res !== e_res || to !== e_to)
         $display("FAIL coincide_result: got %h/%b want %h/%b", res, to, e_res, e_to);
      else n_pass++;
      n_checks++;
      if (lat !== e_lat) $display("FAIL coincide_latency: got %0d want %0d", lat, e_lat);
      else n_pass++;
   endtask

   task automatic test_hold();
      logic [63:0] snap, e_res;
      int bad = 0;
      int guard = 0;
      send({16'h5400, 16'h4C00, 16'h3C00, 16'h4400}, 4'hF,
           {16'h4800, 16'h4400, 16'h3C00, 16'h4000}, 1'b0, 37);
      while (!vec_valid_out && guard < 200) begin
         @(posedge CLK); #1;
         guard++;
      end
      snap = vec_result;
      e_res = exp_res_q.pop_front();
      void'(exp_to_q.pop_front());
      void'(exp_lat_q.pop_front());
      n_checks++;
      if (!vec_valid_out || snap !== e_res)
         $display("FAIL hold_result: got %h want %h", snap, e_res);
      else n_pass++;
      vec_operand  = 64'hCAFE_0000_BEEF_1111;
      vec_mask     = 4'h0;
      vec_valid_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         if (vec_result !== snap || !vec_valid_out || vec_ready_in || !busy) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
      else n_pass++;
      vec_ready_out = 1'b1;
      @(posedge CLK); #1;
      vec_ready_out = 1'b0;
      n_checks++;
      if (vec_ready_in !== 1'b1 || vec_valid_out !== 1'b0)
         $display("FAIL hold_release: got ready_in=%b valid_out=%b want 1/0",
                  vec_ready_in, vec_valid_out);
      else n_pass++;
      @(posedge CLK); #1;
      vec_valid_in = 1'b0;
      n_checks++;
      if (vec_valid_out !== 1'b1 || vec_result !== 64'hCAFE_0000_BEEF_1111)
         $display("FAIL hold_next_accept: got %b/%h want 1/cafe0000beef1111",
                  vec_valid_out, vec_result);
      else n_pass++;
      vec_ready_out = 1'b1;
      @(posedge CLK); #1;
      vec_ready_out = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [63:0] res, e_res, op;
      logic to, ok, e_to;
      int lat, e_lat;
      int guard = 0;
      issued_q.delete();
      send({16'h5400, 16'h4C00, 16'h3C00, 16'h4400}, 4'hF, '0, 1'b0, 0);
      exp_res_q.delete(); exp_to_q.delete(); exp_lat_q.delete();
      while (issued_q.size() < 3 && guard < 200) begin
         @(posedge CLK); #1;
         guard++;
      end
      repeat (2) @(posedge CLK);
      #3;
      nRST = 1'b0;
      #1;
      n_checks++;
      if ({vec_ready_in, vec_valid_out, vec_timeout, sq_valid_in, sq_ready_out, busy} !== 6'b100000
          || vec_result !== 64'h0 || sq_operand !== 16'h0)
         $display("FAIL midreset_outputs: got %b/%h/%h want 100000/0/0",
                  {vec_ready_in, vec_valid_out, vec_timeout, sq_valid_in, sq_ready_out, busy},
                  vec_result, sq_operand);
      else n_pass++;
      @(posedge CLK); #1;
      nRST = 1'b1;
      guard = 0;
      while (!sq_valid_out && guard < 50) begin
         @(posedge CLK); #1;
         guard++;
      end
      @(posedge CLK); #1;
      n_checks++;
      if (!sq_valid_out || busy !== 1'b0 || vec_valid_out !== 1'b0 || sq_ready_out !== 1'b0)
         $display("FAIL midreset_stray: got stub_valid=%b busy=%b valid_out=%b ready_out=%b want 1/0/0/0",
                  sq_valid_out, busy, vec_valid_out, sq_ready_out);
      else n_pass++;
      st_flush = 1'b1;
      @(posedge CLK); #1;
      st_flush = 1'b0;
      op = {16'h1111, 16'h5400, 16'h2222, 16'h4C00};
      send(op, 4'b1011, {sq_model(16'h1111), 16'h5400, sq_model(16'h2222), 16'h4400}, 1'b0, 28);
      collect(res, to, lat, ok);
      e_res = exp_res_q.pop_front(); e_to = exp_to_q.pop_front(); e_lat = exp_lat_q.pop_front();
      n_checks++;
      if (!ok || res !== e_res || to !== e_to || lat !== e_lat)
         $display("FAIL midreset_next: got %h/%b/%0d want %h/%b/%0d", res, to, lat,
                  e_res, e_to, e_lat);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] op, e, res, e_res;
      logic [3:0] m;
      logic to, ok, e_to;
      int lat, e_lat, k;
      for (int n = 0; n < 6; n++) begin
         op = {$urandom, $urandom};
         m  = 4'($urandom_range(0, 15));
         k  = 0;
         for (int i = 0; i < LANES; i++) begin
            e[16*i +: 16] = m[i] ? sq_model(op[16*i +: 16]) : op[16*i +: 16];
            if (m[i]) k++;
         end
         send(op, m, e, 1'b0, 1 + k * 9);
         collect(res, to, lat, ok);
         e_res = exp_res_q.pop_front(); e_to = exp_to_q.pop_front();
         e_lat = exp_lat_q.pop_front();
         n_checks++;
         if (!ok || res !== e_res || to !== e_to || lat !== e_lat)
            $display("FAIL b2b_%0d mask %b: got %h/%b/%0d want %h/%b/%0d", n, m, res, to, lat,
                     e_res, e_to, e_lat);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_partial();
      test_empty();
      test_timeout();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
